// File: rtl/tone_pkg.sv
// Shared note codes, base-frequency table and counter-width helper for the
// polyphonic tone generator.
package tone_pkg;

  typedef enum logic [2:0] {
    NOTE_OFF = 3'd0,
    NOTE_C1  = 3'd1,
    NOTE_D1  = 3'd2,
    NOTE_E1  = 3'd3,
    NOTE_F1  = 3'd4,
    NOTE_G1  = 3'd5,
    NOTE_A0  = 3'd6,
    NOTE_B0  = 3'd7
  } note_e;

  function automatic int unsigned base_freq(input logic [2:0] code);
    case (note_e'(code))
      NOTE_C1: return 33;
      NOTE_D1: return 37;
      NOTE_E1: return 41;
      NOTE_F1: return 44;
      NOTE_G1: return 49;
      NOTE_A0: return 28;
      NOTE_B0: return 31;
      default: return 0;
    endcase
  endfunction

  // Half-period in clk cycles at octave 0; zero for the silent code.
  function automatic int unsigned base_half_period(input int unsigned clk_hz,
                                                   input logic [2:0]  code);
    int unsigned f;
    f = base_freq(code);
    return (f == 0) ? 0 : clk_hz / (2 * f);
  endfunction

  function automatic int unsigned per_w(input int unsigned clk_hz);
    return $clog2(clk_hz / 56) + 1;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: key edge detect, half-period counter, wave and
// release envelope.
module tone_voice
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned ENV_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_on,
  input  logic             tick,
  input  logic [2:0]       note,
  input  logic [2:0]       octave,
  output logic             wave,
  output logic [ENV_W-1:0] env
);

  localparam int unsigned PER_W = per_w(CLK_HZ);
  localparam logic [ENV_W-1:0] ENV_MAX = '1;
  typedef logic [PER_W-1:0] per_t;

  localparam per_t HP_TAB [8] = '{
    per_t'(0),
    per_t'(base_half_period(CLK_HZ, 3'd1)),
    per_t'(base_half_period(CLK_HZ, 3'd2)),
    per_t'(base_half_period(CLK_HZ, 3'd3)),
    per_t'(base_half_period(CLK_HZ, 3'd4)),
    per_t'(base_half_period(CLK_HZ, 3'd5)),
    per_t'(base_half_period(CLK_HZ, 3'd6)),
    per_t'(base_half_period(CLK_HZ, 3'd7))
  };

  logic key_prev;
  logic rise;
  per_t hp;
  per_t cnt;

  always_comb begin
    hp   = HP_TAB[note] >> octave;
    rise = key_on & ~key_prev;
  end

  // hp is sampled only on reload, so note/octave changes never cut a half-period short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev <= 1'b0;
      env      <= '0;
      wave     <= 1'b0;
      cnt      <= '0;
    end else begin
      key_prev <= key_on;
      if (rise) begin
        env  <= ENV_MAX;
        wave <= 1'b0;
        cnt  <= (note == NOTE_OFF) ? '0 : hp - 1'b1;
      end else begin
        if (key_on)
          env <= ENV_MAX;
        else if (tick && env != '0)
          env <= env - 1'b1;

        if (env == '0 || note == NOTE_OFF) begin
          wave <= 1'b0;
          cnt  <= '0;
        end else if (cnt == '0) begin
          wave <= ~wave;
          cnt  <= hp - 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/poly_tone_gen.sv
// Polyphonic square-wave tone generator: VOICES voices mixed, scaled by
// master volume and rendered as a single-bit PWM stream for the amplifier.
module poly_tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned VOICES    = 4,
  parameter int unsigned ENV_W     = 4,
  parameter int unsigned VOL_W     = 4,
  parameter int unsigned PWM_W     = 6,
  parameter int unsigned DECAY_DIV = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VOICES-1:0]     key_on,
  input  logic [3*VOICES-1:0]   note,
  input  logic [3*VOICES-1:0]   octave,
  input  logic [VOL_W-1:0]      volume,
  output logic                  AIN,
  output logic                  GAIN,
  output logic                  NC,
  output logic                  ACTIVE
);

  localparam int unsigned SUM_W  = ENV_W + $clog2(VOICES);
  localparam int unsigned PROD_W = SUM_W + VOL_W;
  localparam int unsigned SHIFT  = PROD_W - PWM_W;
  localparam int unsigned DIV_W  = $clog2(DECAY_DIV + 1);

  logic [DIV_W-1:0]  div;
  logic              tick;
  logic [VOICES-1:0] wave;
  logic [ENV_W-1:0]  env [VOICES];
  logic [SUM_W-1:0]  mix;
  logic [SUM_W-1:0]  mix_next;
  logic              any_env;
  logic [PROD_W-1:0] prod;
  logic [PWM_W-1:0]  level;
  logic [PWM_W-1:0]  level_q;
  logic [PWM_W-1:0]  pwm_cnt;

  assign GAIN = 1'b1;
  assign NC   = 1'b0;

  assign tick = (div == DIV_W'(DECAY_DIV - 1));

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    tone_voice #(
      .CLK_HZ (CLK_HZ),
      .ENV_W  (ENV_W)
    ) u_voice (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_on (key_on[v]),
      .tick   (tick),
      .note   (note[3*v +: 3]),
      .octave (octave[3*v +: 3]),
      .wave   (wave[v]),
      .env    (env[v])
    );
  end

  always_comb begin
    mix_next = '0;
    any_env  = 1'b0;
    for (int unsigned v = 0; v < VOICES; v++) begin
      if (wave[v])
        mix_next = mix_next + SUM_W'(env[v]);
      if (env[v] != '0)
        any_env = 1'b1;
    end
    prod  = PROD_W'(mix) * PROD_W'(volume);
    level = PWM_W'(prod >> SHIFT);
  end

  // level_q only moves at counter wrap so a PWM period never sees two levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= '0;
      mix     <= '0;
      pwm_cnt <= '0;
      level_q <= '0;
      AIN     <= 1'b0;
      ACTIVE  <= 1'b0;
    end else begin
      div     <= tick ? '0 : div + 1'b1;
      mix     <= mix_next;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '1)
        level_q <= level;
      AIN     <= (pwm_cnt < level_q);
      ACTIVE  <= any_env;
    end
  end

endmodule

// File: tb/tb_poly_tone_gen.sv
// Bench for poly_tone_gen: cycle reference model for AIN/ACTIVE/mix under
// random stimulus, plus tables and directed sequences for pitch, volume and decay.
module tb_poly_tone_gen;

  localparam int unsigned CLK_HZ = 100000;
  localparam int unsigned NV     = 4;
  localparam int unsigned DDIV   = 10;
  localparam int          EMAX   = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_on = '0;
  logic [11:0] note = '0;
  logic [11:0] octave = '0;
  logic [3:0]  volume = '0;
  logic        AIN, GAIN, NC, ACTIVE;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  poly_tone_gen #(
    .CLK_HZ    (CLK_HZ),
    .VOICES    (NV),
    .ENV_W     (4),
    .VOL_W     (4),
    .PWM_W     (6),
    .DECAY_DIV (DDIV)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_on (key_on),
    .note   (note),
    .octave (octave),
    .volume (volume),
    .AIN    (AIN),
    .GAIN   (GAIN),
    .NC     (NC),
    .ACTIVE (ACTIVE)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_t;
  int m_env  [NV];
  bit m_wave [NV];
  bit m_prev [NV];
  int m_next [NV];
  int m_mix, m_lvl;
  bit m_ain, m_active;

  function automatic int hp_of(input int n, input int o);
    int freq [8] = '{0, 33, 37, 41, 44, 49, 28, 31};
    if (freq[n] == 0) return 0;
    return (int'(CLK_HZ) / (2 * freq[n])) >>> o;
  endfunction

  function automatic void m_reset();
    m_t = 0; m_mix = 0; m_lvl = 0; m_ain = 0; m_active = 0;
    for (int v = 0; v < NV; v++) begin
      m_env[v] = 0; m_wave[v] = 0; m_prev[v] = 0; m_next[v] = 0;
    end
  endfunction

  function automatic void m_step();
    int  env_o [NV];
    bit  wave_o [NV];
    bit  tick, k, rise;
    int  n, o, sum;
    env_o  = m_env;
    wave_o = m_wave;
    tick   = ((m_t % DDIV) == DDIV - 1);
    for (int v = 0; v < NV; v++) begin
      k    = key_on[v];
      n    = int'(note[3*v +: 3]);
      o    = int'(octave[3*v +: 3]);
      rise = k && !m_prev[v];
      if (rise) begin
        m_env[v]  = EMAX;
        m_wave[v] = 0;
        m_next[v] = (n == 0) ? m_t + 1 : m_t + hp_of(n, o);
      end else begin
        if (env_o[v] == 0 || n == 0) begin
          m_wave[v] = 0;
          m_next[v] = m_t + 1;
        end else if (m_t == m_next[v]) begin
          m_wave[v] = !wave_o[v];
          m_next[v] = m_t + hp_of(n, o);
        end
        if (k) m_env[v] = EMAX;
        else if (tick && env_o[v] > 0) m_env[v] = env_o[v] - 1;
      end
      m_prev[v] = k;
    end
    m_ain = ((m_t % 64) < m_lvl);
    if ((m_t % 64) == 63) m_lvl = (m_mix * int'(volume)) >> 4;
    sum = 0;
    m_active = 0;
    for (int v = 0; v < NV; v++) begin
      if (wave_o[v]) sum += env_o[v];
      if (env_o[v] != 0) m_active = 1;
    end
    m_mix = sum;
    m_t++;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("AIN_model", int'(AIN), int'(m_ain));
        check("ACTIVE_model", int'(ACTIVE), int'(m_active));
        check("MIX_model", int'(u_dut.mix), m_mix);
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_voice(input int v, input bit k, input int n, input int o);
    key_on[v]         = k;
    note[3*v +: 3]    = 3'(n);
    octave[3*v +: 3]  = 3'(o);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick_n(3);
    rst_n = 1'b1;
  endtask

  task automatic wait_w0(input bit val, input int limit, output int n);
    n = 0;
    while (u_dut.g_voice[0].u_voice.wave !== val && n < limit) begin
      tick_n(1);
      n++;
    end
    check("wait_wave0_in_time", int'(n < limit), 1);
  endtask

  task automatic count_ain(output int c);
    c = 0;
    for (int i = 0; i < 64; i++) begin
      tick_n(1);
      c += int'(AIN);
    end
  endtask

  typedef struct { int n; int o; int hp; } hp_vec_t;
  typedef struct { int vol; int lvl; } vol_vec_t;

  initial begin
    hp_vec_t  hp_tab  [8];
    vol_vec_t vol_tab [6];
    int n, c, hold;

    hp_tab = '{'{6, 0, 1785}, '{6, 7, 13}, '{1, 3, 189}, '{2, 3, 168},
               '{5, 2, 255},  '{7, 1, 806}, '{3, 4, 76},  '{4, 5, 35}};
    vol_tab = '{'{15, 14}, '{8, 7}, '{4, 3}, '{1, 0}, '{0, 0}, '{10, 9}};

    // Reset with a key already held, then release.
    set_voice(0, 1, 1, 3);
    volume = 4'd15;
    rst_n  = 1'b0;
    tick_n(3);
    check("rst_AIN", int'(AIN), 0);
    check("rst_ACTIVE", int'(ACTIVE), 0);
    check("rst_env0", int'(u_dut.g_voice[0].u_voice.env), 0);
    check("GAIN", int'(GAIN), 1);
    check("NC", int'(NC), 0);
    rst_n = 1'b1;
    tick_n(2);
    check("active_after_rst", int'(ACTIVE), 1);
    tick_n(30);
    check("env_held_max", int'(u_dut.g_voice[0].u_voice.env), 15);

    // Half-period per note/octave.
    set_voice(0, 0, 1, 3);
    tick_n(2);
    for (int i = 0; i < 8; i++) begin
      set_voice(0, 1, hp_tab[i].n, hp_tab[i].o);
      tick_n(1);
      wait_w0(1'b1, 2 * hp_tab[i].hp + 10, n);
      wait_w0(1'b0, 2 * hp_tab[i].hp + 10, n);
      check($sformatf("half_period_n%0d_o%0d", hp_tab[i].n, hp_tab[i].o), n, hp_tab[i].hp);
      set_voice(0, 0, hp_tab[i].n, hp_tab[i].o);
      tick_n(2);
    end

    // Note change mid half-period: old length completes, next uses new.
    set_voice(0, 1, 1, 3);
    tick_n(1);
    wait_w0(1'b1, 400, n);
    tick_n(50);
    set_voice(0, 1, 2, 3);
    wait_w0(1'b0, 400, n);
    check("note_change_current_hp", n, 139);
    wait_w0(1'b1, 400, n);
    check("note_change_next_hp", n, 168);

    // Volume scaling, single voice at full envelope.
    for (int i = 0; i < 6; i++) begin
      key_on = '0;
      do_reset();
      volume = 4'(vol_tab[i].vol);
      set_voice(0, 1, 1, 2);
      tick_n(1);
      wait_w0(1'b1, 500, n);
      tick_n(70);
      count_ain(c);
      check($sformatf("duty_vol%0d", vol_tab[i].vol), c, vol_tab[i].lvl);
      check($sformatf("level_vol%0d", vol_tab[i].vol), int'(u_dut.level_q), vol_tab[i].lvl);
    end

    // All voices aligned high at full volume.
    key_on = '0;
    do_reset();
    volume = 4'd15;
    for (int v = 0; v < NV; v++) set_voice(v, 1, 1, 2);
    tick_n(1);
    wait_w0(1'b1, 500, n);
    tick_n(70);
    check("mix_all_voices", int'(u_dut.mix), 60);
    check("level_all_voices", int'(u_dut.level_q), 56);
    count_ain(c);
    check("duty_all_voices", c, 56);

    // Release decay and ACTIVE drop.
    key_on = '0;
    do_reset();
    set_voice(0, 1, 0, 0);
    tick_n(5);
    set_voice(0, 0, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (u_dut.g_voice[0].u_voice.env != 0 && n < 200);
    check("decay_length_in_range", int'(n >= 141 && n <= 150), 1);
    check("active_at_env0", int'(ACTIVE), 1);
    @(negedge clk);
    check("active_after_env0", int'(ACTIVE), 0);
    tick_n(1);

    // Randomized segments against the model.
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      for (int v = 0; v < NV; v++) begin
        if ($urandom_range(0, 1) == 1) key_on[v] = ~key_on[v];
        if ($urandom_range(0, 2) == 0) begin
          note[3*v +: 3]   = 3'($urandom_range(0, 7));
          octave[3*v +: 3] = 3'($urandom_range(3, 7));
        end
      end
      if ($urandom_range(0, 3) == 0) volume = 4'($urandom_range(0, 15));
      hold = $urandom_range(20, 300);
      tick_n(hold);
    end

    // Mid-note reset must silence the output.
    key_on = '1;
    tick_n(100);
    rst_n = 1'b0;
    #1;
    check("midnote_rst_AIN", int'(AIN), 0);
    check("midnote_rst_ACTIVE", int'(ACTIVE), 0);
    tick_n(2);
    rst_n = 1'b1;
    tick_n(2);
    check("midnote_rst_reactivate", int'(ACTIVE), 1);
    tick_n(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
